// File: rtl/conv_adder_tree.sv
// Pipelined signed adder tree for convolution: sums KERNEL_SIZE^2 products exactly,
// adds a bias and saturates to DATA_WIDTH. One global stall driven by out_ready.
module conv_adder_tree #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] products,
  input  logic [DATA_WIDTH-1:0]                         bias,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  output logic [DATA_WIDTH-1:0]                         sum,
  output logic                                          saturated,
  output logic                                          out_valid,
  input  logic                                          out_ready
);

  localparam int N      = KERNEL_SIZE * KERNEL_SIZE;
  localparam int LEVELS = $clog2(N);
  localparam int ACC_W  = DATA_WIDTH + LEVELS + 1;

  // Number of live elements at tree level k (level 0 is the capture stage).
  function automatic int lvl_cnt(input int k);
    int c;
    c = N;
    for (int i = 0; i < k; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // All levels share one flat register array; this is where level k starts.
  function automatic int lvl_off(input int k);
    int o;
    o = 0;
    for (int i = 0; i < k; i++) o += lvl_cnt(i);
    return o;
  endfunction

  function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_WIDTH-1:0] x);
    return {{(ACC_W-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
  endfunction

  localparam int TOT  = lvl_off(LEVELS + 1);
  localparam int ROOT = lvl_off(LEVELS);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_W-1:0] tree_q [TOT];
  logic signed [ACC_W-1:0] tree_d [TOT];
  logic signed [ACC_W-1:0] bias_q [LEVELS+1];
  logic        [LEVELS:0]  vld_q;
  logic signed [ACC_W-1:0] total;
  logic [DATA_WIDTH-1:0]   sum_d;
  logic                    sat_d;
  logic                    advance;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  for (genvar i = 0; i < N; i++) begin : g_capture
    assign tree_d[i] = sext(products[i*DATA_WIDTH +: DATA_WIDTH]);
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int PREV_CNT = lvl_cnt(k - 1);
    localparam int PREV_OFF = lvl_off(k - 1);
    localparam int CUR_OFF  = lvl_off(k);
    for (genvar j = 0; j < lvl_cnt(k); j++) begin : g_node
      if (2*j + 1 < PREV_CNT) begin : g_add
        assign tree_d[CUR_OFF+j] = tree_q[PREV_OFF+2*j] + tree_q[PREV_OFF+2*j+1];
      end else begin : g_pass
        assign tree_d[CUR_OFF+j] = tree_q[PREV_OFF+2*j];
      end
    end
  end

  // ACC_W leaves headroom for N products plus the bias, so total never wraps.
  assign total = tree_q[ROOT] + bias_q[LEVELS];

  // NOTE: combinational outputs get a default before any branch so no latch is inferred.
  always_comb begin
    sum_d = total[DATA_WIDTH-1:0];
    sat_d = 1'b0;
    if (total > SAT_MAX) begin
      sum_d = SAT_MAX[DATA_WIDTH-1:0];
      sat_d = 1'b1;
    end else if (total < SAT_MIN) begin
      sum_d = SAT_MIN[DATA_WIDTH-1:0];
      sat_d = 1'b1;
    end
  end

  // NOTE: state is assigned with <= so every stage samples the previous stage's old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: data registers clear too; they are plain flops, not a RAM, and no stale partial sum survives reset.
      tree_q    <= '{default: '0};
      bias_q    <= '{default: '0};
      vld_q     <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      saturated <= 1'b0;
    end else if (advance) begin
      tree_q    <= tree_d;
      bias_q[0] <= sext(bias);
      for (int s = 1; s <= LEVELS; s++) bias_q[s] <= bias_q[s-1];
      vld_q[0]  <= in_valid;
      for (int s = 1; s <= LEVELS; s++) vld_q[s] <= vld_q[s-1];
      out_valid <= vld_q[LEVELS];
      sum       <= sum_d;
      saturated <= sat_d;
    end
  end

endmodule

// File: tb/tb_conv_adder_tree.sv
// Directed bench for conv_adder_tree: table of single-pulse vectors plus
// reset, backpressure and mid-stream reset sequences.
module tb_conv_adder_tree;

  localparam int DW = 32;
  localparam int KS = 3;
  localparam int N  = KS * KS;
  localparam int L  = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic [N*DW-1:0]   products;
  logic [DW-1:0]     bias;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     sum;
  logic              saturated;
  logic              out_valid;
  logic              out_ready;

  always #5 clk = ~clk;

  conv_adder_tree #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS)) dut (
    .clk       (clk),
    .reset     (reset),
    .products  (products),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .saturated (saturated),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef logic [N-1:0][DW-1:0] lanes_t;

  typedef struct {
    string         name;
    lanes_t        lanes;
    logic [DW-1:0] bias;
    logic [DW-1:0] exp_sum;
    logic          exp_sat;
  } vec_t;

  typedef struct {
    logic [DW-1:0] s;
    logic          sat;
  } res_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  res_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model(input lanes_t l, input logic [DW-1:0] b);
    longint t;
    res_t   r;
    t = longint'($signed(b));
    for (int i = 0; i < N; i++) t += longint'($signed(l[i]));
    if (t > 64'sd2147483647) begin
      r.s = 32'h7FFF_FFFF; r.sat = 1'b1;
    end else if (t < -64'sd2147483648) begin
      r.s = 32'h8000_0000; r.sat = 1'b1;
    end else begin
      r.s = t[DW-1:0];     r.sat = 1'b0;
    end
    return r;
  endfunction

  function automatic bit stalled(input int c);
    return (c >= 8 && c <= 10) || (c >= 15 && c <= 17);
  endfunction

  // Single vector through an otherwise idle pipe: out_valid must first show
  // L-1 edges after the accepting edge (the accepting edge is cycle 1 of L).
  task automatic pulse(input string name, input lanes_t l, input logic [DW-1:0] b,
                       input logic [DW-1:0] es, input logic esat);
    int lat;
    products = l;
    bias     = b;
    in_valid = 1'b1;
    #1;
    check({name, "/in_ready"}, 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({name, "/latency"}, 64'(lat), 64'(L - 1));
    check({name, "/sum"}, 64'(sum), 64'(es));
    check({name, "/saturated"}, 64'(saturated), 64'(esat));
    step();
    check({name, "/single_beat"}, 64'(out_valid), 64'(0));
  endtask

  vec_t          tbl[9];
  lanes_t        bp_l[20];
  logic [DW-1:0] bp_b[20];
  lanes_t        ones;
  res_t          r;
  logic [DW-1:0] tmp;
  int            sent, got, cyc, extra;

  initial begin
    // Directed vectors with hand-computed results.
    for (int k = 0; k < 9; k++) begin
      tbl[k].lanes = '0;
      tbl[k].bias  = '0;
    end
    tbl[0].name = "basic";
    for (int i = 0; i < N; i++) tbl[0].lanes[i] = DW'(i + 1);
    tbl[0].exp_sum = 32'd45;         tbl[0].exp_sat = 1'b0;

    tbl[1].name = "signed_mix";
    tbl[1].lanes[0] = -32'sd5;  tbl[1].lanes[1] = 32'sd7;   tbl[1].lanes[2] = -32'sd3;
    tbl[1].lanes[3] = 32'sd0;   tbl[1].lanes[4] = 32'sd12;  tbl[1].lanes[5] = -32'sd1;
    tbl[1].lanes[6] = 32'sd4;   tbl[1].lanes[7] = -32'sd20; tbl[1].lanes[8] = 32'sd2;
    tbl[1].bias = -32'sd100;
    tbl[1].exp_sum = 32'hFFFF_FF98;  tbl[1].exp_sat = 1'b0;

    tbl[2].name = "sat_pos";
    for (int i = 0; i < N; i++) tbl[2].lanes[i] = 32'h7FFF_FFFF;
    tbl[2].bias = 32'd1;
    tbl[2].exp_sum = 32'h7FFF_FFFF;  tbl[2].exp_sat = 1'b1;

    tbl[3].name = "sat_neg";
    for (int i = 0; i < N; i++) tbl[3].lanes[i] = 32'h8000_0000;
    tbl[3].bias = 32'hFFFF_FFFF;
    tbl[3].exp_sum = 32'h8000_0000;  tbl[3].exp_sat = 1'b1;

    tbl[4].name = "max_exact";
    tbl[4].lanes[0] = 32'h7FFF_FFFF; tbl[4].lanes[1] = 32'd1;
    tbl[4].bias = 32'hFFFF_FFFF;
    tbl[4].exp_sum = 32'h7FFF_FFFF;  tbl[4].exp_sat = 1'b0;

    tbl[5].name = "max_plus_one";
    tbl[5].lanes[0] = 32'h7FFF_FFFF;
    tbl[5].bias = 32'd1;
    tbl[5].exp_sum = 32'h7FFF_FFFF;  tbl[5].exp_sat = 1'b1;

    tbl[6].name = "min_exact";
    tbl[6].lanes[0] = 32'h8000_0000;
    tbl[6].exp_sum = 32'h8000_0000;  tbl[6].exp_sat = 1'b0;

    tbl[7].name = "min_minus_one_lane8";
    tbl[7].lanes[0] = 32'h8000_0000; tbl[7].lanes[8] = 32'hFFFF_FFFF;
    tbl[7].exp_sum = 32'h8000_0000;  tbl[7].exp_sat = 1'b1;

    tbl[8].name = "odd_lane_only";
    tbl[8].lanes[8] = 32'd1000;
    tbl[8].bias = 32'd5;
    tbl[8].exp_sum = 32'd1005;       tbl[8].exp_sat = 1'b0;

    for (int i = 0; i < N; i++) ones[i] = 32'd1;

    // Reset held 3 cycles with live-looking traffic; reset must win.
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    bias      = $urandom;
    repeat (3) begin
      for (int i = 0; i < N; i++) products[i*DW +: DW] = $urandom;
      step();
    end
    check("reset/out_valid", 64'(out_valid), 64'(0));
    check("reset/sum", 64'(sum), 64'(0));
    check("reset/saturated", 64'(saturated), 64'(0));
    check("reset/in_ready", 64'(in_ready), 64'(1));
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("post_reset/out_valid", 64'(out_valid), 64'(0));
    end

    for (int k = 0; k < 9; k++)
      pulse(tbl[k].name, tbl[k].lanes, tbl[k].bias, tbl[k].exp_sum, tbl[k].exp_sat);

    // Backpressure: 20 back-to-back vectors, out_ready low for two 3-cycle windows.
    for (int v = 0; v < 20; v++) begin
      for (int i = 0; i < N; i++) begin
        if (v % 2 == 1) begin
          bp_l[v][i] = $urandom;
        end else begin
          tmp = $urandom_range(2000, 0);
          bp_l[v][i] = tmp - 32'd1000;
        end
      end
      bp_b[v] = (v % 3 == 0) ? $urandom : 32'd7;
    end
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 20 && cyc < 200) begin
      out_ready = !stalled(cyc);
      in_valid  = (sent < 20);
      if (sent < 20) begin
        products = bp_l[sent];
        bias     = bp_b[sent];
      end
      #1;
      check("bp/in_ready", 64'(in_ready), 64'(!stalled(cyc)));
      if (stalled(cyc)) begin
        check("bp/stall_out_valid", 64'(out_valid), 64'(1));
        if (exp_q.size() > 0) check("bp/stall_sum", 64'(sum), 64'(exp_q[0].s));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(bp_l[sent], bp_b[sent]));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          check("bp/sum", 64'(sum), 64'(r.s));
          check("bp/saturated", 64'(saturated), 64'(r.sat));
        end else begin
          check("bp/spurious_out", 64'(out_valid), 64'(0));
        end
        got++;
      end
      step();
      cyc++;
    end
    check("bp/count", 64'(got), 64'(20));
    check("bp/leftover", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();

    // Mid-stream reset: four vectors in flight are discarded.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < N; i++) products[i*DW +: DW] = $urandom_range(500, 1);
      bias     = 32'd3;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid/flushed", 64'(out_valid), 64'(0));
    pulse("rst_mid", ones, 32'd0, 32'd9, 1'b0);
    extra = 0;
    repeat (20) begin
      step();
      if (out_valid) extra++;
    end
    check("rst_mid/extra_outputs", 64'(extra), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_adder_tree.md
# conv_adder_tree

- Pipelined signed reduction stage directly downstream of the kernel multiplier.
- Takes the KERNEL_SIZE² per-tap products as one flat bus and sums them exactly.
- Adds a per-output bias, then saturates to DATA_WIDTH to produce one convolution output per accepted vector.
- Valid/ready on both sides; the whole pipeline stalls globally under downstream backpressure.

## Interface

Parameters:
- DATA_WIDTH, 32, width of each product, the bias and the result; signed two's complement.
- KERNEL_SIZE, 3, kernel edge; N = KERNEL_SIZE² lanes.
- Derived, not overridable: N = KERNEL_SIZE²; LEVELS = ceil(log2(N)) (4 for N=9); ACC_W = DATA_WIDTH + LEVELS + 1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- products  in  N*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH], signed; same packing as the multiplier result bus.
- bias  in  DATA_WIDTH  signed; sampled together with products.
- in_valid  in  1  products/bias valid this cycle.
- in_ready  out  1  stage can accept this cycle.
- sum  out  DATA_WIDTH  saturated signed result.
- saturated  out  1  sum was clipped; qualified by out_valid.
- out_valid  out  1  sum/saturated valid.
- out_ready  in  1  consumer accepts this cycle.

## Operation

- Pipeline: capture stage → LEVELS reduction stages → output stage. Every stage carries a valid bit.
- Capture stage: registers each lane sign-extended to ACC_W, and registers bias sign-extended to ACC_W.
- Reduction stage k: out[j] = in[2j] + in[2j+1]. An odd trailing element passes through unchanged. Bias travels alongside, unchanged.
- All adds are exact at ACC_W; overflow inside the tree is impossible by construction.
- Output stage: t = tree_sum + bias.
  - t > 2^(DATA_WIDTH-1)-1: sum = 0x7FF..F, saturated = 1.
  - t < -2^(DATA_WIDTH-1): sum = 0x800..0, saturated = 1.
  - Otherwise: sum = t[DATA_WIDTH-1:0], saturated = 0.
- Flow control:
  - advance = !(out_valid && !out_ready).
  - in_ready = advance.
  - When advance = 1, all stages shift one step. When advance = 0, every register holds, including sum, saturated and out_valid.
- A transfer occurs on in_valid && in_ready. A stage with in_valid = 0 and advance = 1 loads a bubble (valid = 0).
- Bubbles are not collapsed during a stall. Throughput is one vector per cycle while out_ready = 1.
- Ordering: outputs appear strictly in acceptance order; no drop, no duplication.
- Reset:
  - All valid bits, sum and saturated are 0 on the cycle after reset is sampled high. Data registers also clear to 0.
  - in_ready = 1 during and after reset, because out_valid = 0.
  - Reset mid-stream discards every in-flight vector; nothing from before reset may appear after it.
- Simultaneous reset and in_valid: reset wins; the vector is not captured.

## Timing

- Latency L = LEVELS + 2 cycles, from the accepting edge to out_valid high (6 for KERNEL_SIZE = 3; 4 for KERNEL_SIZE = 2, where LEVELS = 2).
- A vector accepted at edge n gives out_valid = 1 after edge n+L-1, assuming no stall. Each stalled cycle adds one.
- in_ready depends combinationally only on out_valid (registered) and out_ready. No combinational path exists from in_valid, products or bias to any output.
- out_valid, sum and saturated are driven directly from flops and are stable while out_valid && !out_ready.
- Reset outputs: sum = 0, saturated = 0, out_valid = 0, in_ready = 1.

## Test plan

All scenarios use DATA_WIDTH = 32, KERNEL_SIZE = 3.

1. Reset: hold reset for 3 cycles with random inputs and in_valid = 1 → out_valid = 0, sum = 0, saturated = 0, in_ready = 1; out_valid stays 0 for 10 cycles after reset with in_valid = 0.
2. Basic sum: lanes 0..8 = 1..9, bias = 0, single pulse, out_ready = 1 → exactly one out_valid cycle, 6 cycles after acceptance, with sum = 45 and saturated = 0.
3. Signed mix: lanes = {-5, 7, -3, 0, 12, -1, 4, -20, 2}, bias = -100 → sum = -104 (0xFFFFFF98), saturated = 0.
4. Saturation, both directions:
   - All lanes 0x7FFFFFFF, bias = 1 → sum = 0x7FFFFFFF, saturated = 1.
   - All lanes 0x80000000, bias = -1 → sum = 0x80000000, saturated = 1.
   - Lanes {0x7FFFFFFF, 1, 0, …}, bias = -1 → sum = 0x7FFFFFFF, saturated = 0.
5. Backpressure: stream 20 random vectors back-to-back, drop out_ready for 3 cycles twice mid-stream →
   - All 20 results match the reference model, in order.
   - in_ready = 0 exactly in the stalled cycles.
   - sum and out_valid are held constant while stalled.
6. Reset mid-operation: accept 4 vectors, assert reset for 1 cycle 2 cycles later, then send one vector with lanes = 1 and bias = 0 → the only post-reset output is sum = 9, 6 cycles after its acceptance.
